atm_txn_ctrl: RTL
=================

# atm_txn_ctrl

Transaction controller for the ATM datapath. It sequences a session as card insert, PIN check, menu, deposit or withdraw amount entry, and commit. It owns the account balance register and the running transaction amount. It sits downstream of the button debouncers (consumes one-cycle pulses) and upstream of the BCD/seven-segment display path, which shows `amount` or `balance`.

## Interface
Parameters:
- `PIN`, 6'b101101, correct PIN presented on `sw`
- `MAX_TRIES`, 3, wrong-PIN attempts before lockout (1..7)
- `STEP`, 8'd5, amount increment/decrement per button pulse
- `INIT_BAL`, 8'd100, balance after reset
- `TIMEOUT`, 24'd10_000_000, idle cycles before session abort

Ports (one clock `clk`; `reset` is asynchronous, active-high):
- `clk`  in  1  system clock
- `reset`  in  1  async active-high reset
- `card_in`  in  1  level, card present
- `sw`  in  6  PIN switches
- `up`  in  1  debounced one-cycle pulse
- `down`  in  1  debounced one-cycle pulse
- `enter`  in  1  debounced one-cycle pulse
- `cancel`  in  1  debounced one-cycle pulse
- `balance`  out  8  account balance
- `amount`  out  8  pending transaction amount
- `state`  out  3  current FSM state code
- `led_auth`  out  1  high in MENU/DEP/WDR
- `led_locked`  out  1  high in LOCKED
- `err`  out  1  one-cycle pulse on rejected PIN or transaction

## Operation
- States: IDLE=0, PIN=1, MENU=2, DEP=3, WDR=4, LOCKED=5. Codes 6 and 7 are unused and return to IDLE.
- IDLE: `card_in`=1 → PIN. `tries` cleared.
- PIN:
  - `enter` with `sw`==PIN → MENU, `tries`←0.
  - `enter` with mismatch → `err`, `tries`+1. If the new `tries`==MAX_TRIES → LOCKED, else stay in PIN.
- MENU:
  - `up` alone → DEP.
  - `down` alone → WDR.
  - `cancel` → IDLE.
  - `up`&`down` together → ignored.
- DEP/WDR amount entry:
  - `up` → `amount`+STEP, saturating at 255.
  - `down` → `amount`−STEP, saturating at 0.
  - both pulses together → no change.
- DEP commit (`enter`): if `balance`+`amount` > 255 (9-bit compare) → `err`, balance unchanged. Else `balance`←`balance`+`amount`. Both cases → MENU.
- WDR commit (`enter`): if `amount` > `balance` → `err`, balance unchanged. Else `balance`←`balance`−`amount`. Both cases → MENU.
- `amount` is cleared on every exit from DEP/WDR (commit, cancel, abort).
- `cancel` in DEP/WDR → MENU, no commit. `cancel` has priority over `enter` in the same cycle.
- Commit with `amount`=0 → no `err`, balance unchanged, → MENU.
- Abort: `card_in`=0 in PIN/MENU/DEP/WDR → IDLE. Abort has priority over every pulse in that cycle. Balance is retained.
- Timeout: no `up`/`down`/`enter`/`cancel` pulse for TIMEOUT consecutive cycles in PIN/MENU/DEP/WDR → IDLE.
- LOCKED: all inputs ignored; exits only via `reset`.
- `balance` changes only by commit or reset.

## Timing
- All outputs registered. Reset values:
  - `state`=IDLE
  - `balance`=INIT_BAL
  - `amount`=0
  - `err`=0, `led_auth`=0, `led_locked`=0
  - `tries`=0, timer=0
- Pulse at cycle n → state/amount/balance updated at edge n+1, visible in cycle n+1. `err` is high for exactly cycle n+1.
- Back-to-back pulses on consecutive cycles are each honoured.
- Timer:
  - clears on any pulse and on entering IDLE.
  - abort occurs on the cycle the count reaches TIMEOUT.
  - holds at 0 in IDLE/LOCKED.
- Reset asserted mid-transaction: immediate (async) return to reset values. Pending amount is discarded.

## Structure
- Package `atm_pkg`: state encoding constants (3-bit), width constant AMT_W=8.
- Sub-module `atm_idle_timer`:
  - parameter TIMEOUT
  - inputs `clk`, `reset`, `run`, `kick`
  - output `expired` (one-cycle)
- Controller FSM, tries counter, and amount/balance arithmetic stay in `atm_txn_ctrl`.

## Test plan
- Reset; card_in=1; sw=101101, enter → state MENU, led_auth=1, balance=100, err never high.
- Three enters with sw=000000 → err pulses 3×, state LOCKED, led_locked=1. Further pulses ignored until reset.
- MENU, up → DEP; up×4 (amount=20), enter → balance=120, amount=0, state MENU. Then down → WDR; up×30 (amount=150), enter → err, balance=120.
- DEP; up×52 → amount saturates at 255. down×60 → amount 0. Separately, with balance=250, deposit 10 → err, balance=250.
- WDR with amount=15; same-cycle enter+cancel → MENU, balance unchanged. card_in dropped mid-DEP → IDLE next cycle, amount=0.
- TIMEOUT overridden to 16: idle 16 cycles in MENU → IDLE. Reset asserted mid-WDR → all outputs at reset values before the next clk edge.

Source files
------------

// File: rtl/atm_pkg.sv
`default_nettype none
// atm_pkg: state codes, datapath width and saturating helpers for the ATM controller.
// Rev 1.0
package atm_pkg;

  localparam int AMT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PIN    = 3'd1,
    ST_MENU   = 3'd2,
    ST_DEP    = 3'd3,
    ST_WDR    = 3'd4,
    ST_LOCKED = 3'd5
  } state_t;

  function automatic logic [AMT_W-1:0] sat_add(input logic [AMT_W-1:0] a,
                                               input logic [AMT_W-1:0] b);
    logic [AMT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[AMT_W] ? {AMT_W{1'b1}} : s[AMT_W-1:0];
  endfunction

  function automatic logic [AMT_W-1:0] sat_sub(input logic [AMT_W-1:0] a,
                                               input logic [AMT_W-1:0] b);
    return (a < b) ? '0 : a - b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/atm_idle_timer.sv
`default_nettype none
// atm_idle_timer: counts pulse-free cycles while a session is active; expired marks the abort cycle.
// Rev 1.0
module atm_idle_timer #(
  parameter logic [23:0] TIMEOUT = 24'd10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic kick,
  output logic expired
);

  logic [23:0] count;

  // Fires on the cycle whose edge would bring the count to TIMEOUT.
  assign expired = run && !kick && (count == TIMEOUT - 24'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!run || kick || expired) begin
      count <= '0;
    end else begin
      count <= count + 24'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/atm_txn_ctrl.sv
`default_nettype none
// atm_txn_ctrl: ATM session FSM with PIN check, lockout, amount entry and balance commit.
// Rev 1.0
module atm_txn_ctrl
  import atm_pkg::*;
#(
  parameter logic [5:0]  PIN       = 6'b101101,
  parameter int          MAX_TRIES = 3,
  parameter logic [7:0]  STEP      = 8'd5,
  parameter logic [7:0]  INIT_BAL  = 8'd100,
  parameter logic [23:0] TIMEOUT   = 24'd10_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             card_in,
  input  logic [5:0]       sw,
  input  logic             up,
  input  logic             down,
  input  logic             enter,
  input  logic             cancel,
  output logic [AMT_W-1:0] balance,
  output logic [AMT_W-1:0] amount,
  output logic [2:0]       state,
  output logic             led_auth,
  output logic             led_locked,
  output logic             err
);

  localparam logic [2:0] TRY_LIM = 3'(MAX_TRIES);

  state_t           cur, nxt;
  logic [AMT_W-1:0] bal_nxt, amt_nxt;
  logic [2:0]       tries, tries_nxt;
  logic             err_nxt;
  logic             pulse, run, expired;
  logic [AMT_W:0]   dep_sum;

  assign pulse   = up | down | enter | cancel;
  assign run     = (cur == ST_PIN) || (cur == ST_MENU) || (cur == ST_DEP) || (cur == ST_WDR);
  assign dep_sum = {1'b0, balance} + {1'b0, amount};
  assign state   = cur;

  atm_idle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .kick    (pulse),
    .expired (expired)
  );

  always_comb begin
    nxt       = cur;
    bal_nxt   = balance;
    amt_nxt   = amount;
    tries_nxt = tries;
    err_nxt   = 1'b0;
    case (cur)
      ST_IDLE: begin
        tries_nxt = '0;
        if (card_in) nxt = ST_PIN;
      end
      ST_LOCKED: ;
      ST_PIN, ST_MENU, ST_DEP, ST_WDR: begin
        // Card removal and timeout outrank every pulse in the same cycle.
        if (!card_in || expired) begin
          nxt     = ST_IDLE;
          amt_nxt = '0;
        end else if (cur == ST_PIN) begin
          if (enter) begin
            if (sw == PIN) begin
              nxt       = ST_MENU;
              tries_nxt = '0;
            end else begin
              err_nxt   = 1'b1;
              tries_nxt = tries + 3'd1;
              if (tries_nxt == TRY_LIM) nxt = ST_LOCKED;
            end
          end
        end else if (cur == ST_MENU) begin
          if (cancel)             nxt = ST_IDLE;
          else if (up && !down)   nxt = ST_DEP;
          else if (down && !up)   nxt = ST_WDR;
        end else begin
          if (cancel) begin
            nxt     = ST_MENU;
            amt_nxt = '0;
          end else if (enter) begin
            nxt     = ST_MENU;
            amt_nxt = '0;
            if (cur == ST_DEP) begin
              if (dep_sum[AMT_W]) err_nxt = 1'b1;
              else                bal_nxt = dep_sum[AMT_W-1:0];
            end else begin
              if (amount > balance) err_nxt = 1'b1;
              else                  bal_nxt = balance - amount;
            end
          end else if (up && !down) begin
            amt_nxt = sat_add(amount, STEP);
          end else if (down && !up) begin
            amt_nxt = sat_sub(amount, STEP);
          end
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur        <= ST_IDLE;
      balance    <= INIT_BAL;
      amount     <= '0;
      tries      <= '0;
      err        <= 1'b0;
      led_auth   <= 1'b0;
      led_locked <= 1'b0;
    end else begin
      cur        <= nxt;
      balance    <= bal_nxt;
      amount     <= amt_nxt;
      tries      <= tries_nxt;
      err        <= err_nxt;
      led_auth   <= (nxt == ST_MENU) || (nxt == ST_DEP) || (nxt == ST_WDR);
      led_locked <= (nxt == ST_LOCKED);
    end
  end

endmodule
`default_nettype wire
